// File: rtl/remote_cmd_arbiter_if.sv
// Bundle between the remote-command arbiter, its requesters and the UART command link.
// The slave modport is the arbiter side; the master modport is the requester/link side.
interface remote_cmd_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req;
    logic [16*NUM_REQ-1:0] req_cmd;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    done;
    logic [7:0]            resp_out;
    logic                  timeout;
    logic                  snd_cmd;
    logic [15:0]           cmd;
    logic                  cmd_snt;
    logic [7:0]            resp;
    logic                  resp_rdy;

    modport slave (
        input  req, req_cmd, cmd_snt, resp, resp_rdy,
        output gnt, done, resp_out, timeout, snd_cmd, cmd
    );

    modport master (
        output req, req_cmd, cmd_snt, resp, resp_rdy,
        input  gnt, done, resp_out, timeout, snd_cmd, cmd
    );
endinterface

// File: rtl/remote_cmd_arbiter.sv
// Round-robin arbiter that shares one remote command link among NUM_REQ requesters,
// running one command/response transaction at a time with a response timeout.
module remote_cmd_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int RESP_TIMEOUT = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    remote_cmd_arbiter_if.slave  bus_if
);
    localparam int TW = $clog2(RESP_TIMEOUT + 1);
    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SNT  = 2'd1,
        WAIT_RESP = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] done_q;
    logic [7:0]         resp_out_q;
    logic               timeout_q;
    logic               snd_cmd_q;
    logic [15:0]        cmd_q;
    logic [TW-1:0]      timer_q;
    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      cur_q;

    logic               pick_valid_s;
    logic [PW-1:0]      pick_idx_s;
    logic [PW-1:0]      idx_s;
    logic               expire_s;

    // Round-robin search: first requester at ptr+1, ptr+2, ... wrapping back to ptr.
    always_comb begin
        pick_valid_s = 1'b0;
        pick_idx_s   = '0;
        idx_s        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s = PW'((int'(ptr_q) + k) % NUM_REQ);
            if (!pick_valid_s && bus_if.req[idx_s]) begin
                pick_valid_s = 1'b1;
                pick_idx_s   = idx_s;
            end else begin
                pick_valid_s = pick_valid_s;
            end
        end
    end

    // >= rather than == so a timer that overran during a late cmd_snt still expires.
    assign expire_s = (timer_q >= TW'(RESP_TIMEOUT - 1));

    // Transaction FSM with all link and requester outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            done_q     <= '0;
            resp_out_q <= 8'h00;
            timeout_q  <= 1'b0;
            snd_cmd_q  <= 1'b0;
            cmd_q      <= 16'h0000;
            timer_q    <= '0;
            ptr_q      <= PW'(NUM_REQ - 1);
            cur_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= '0;
                    if (pick_valid_s) begin
                        gnt_q     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
                        cur_q     <= pick_idx_s;
                        cmd_q     <= bus_if.req_cmd[{pick_idx_s, 4'b0000} +: 16];
                        snd_cmd_q <= 1'b1;
                        timer_q   <= '0;
                        state_q   <= WAIT_SNT;
                    end else begin
                        gnt_q     <= '0;
                        snd_cmd_q <= 1'b0;
                    end
                end
                WAIT_SNT: begin
                    snd_cmd_q <= 1'b0;
                    timer_q   <= timer_q + TW'(1);
                    if (bus_if.cmd_snt) begin
                        state_q <= WAIT_RESP;
                    end else if (expire_s) begin
                        resp_out_q <= 8'h00;
                        timeout_q  <= 1'b1;
                        done_q     <= gnt_q;
                        state_q    <= DONE;
                    end else begin
                        state_q <= WAIT_SNT;
                    end
                end
                WAIT_RESP: begin
                    snd_cmd_q <= 1'b0;
                    if (bus_if.resp_rdy) begin
                        resp_out_q <= bus_if.resp;
                        timeout_q  <= 1'b0;
                        done_q     <= gnt_q;
                        state_q    <= DONE;
                    end else if (expire_s) begin
                        resp_out_q <= 8'h00;
                        timeout_q  <= 1'b1;
                        done_q     <= gnt_q;
                        state_q    <= DONE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                DONE: begin
                    gnt_q     <= '0;
                    done_q    <= '0;
                    snd_cmd_q <= 1'b0;
                    ptr_q     <= cur_q;
                    state_q   <= IDLE;
                end
                default: begin
                    gnt_q     <= '0;
                    done_q    <= '0;
                    snd_cmd_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign bus_if.gnt      = gnt_q;
    assign bus_if.done     = done_q;
    assign bus_if.resp_out = resp_out_q;
    assign bus_if.timeout  = timeout_q;
    assign bus_if.snd_cmd  = snd_cmd_q;
    assign bus_if.cmd      = cmd_q;
endmodule

// File: tb/tb_remote_cmd_arbiter.sv
// Directed bench for remote_cmd_arbiter: a 2-requester instance with a long timeout and
// a 3-requester instance with RESP_TIMEOUT=16, both driven and sampled on the falling edge.
module tb_remote_cmd_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    remote_cmd_arbiter_if #(.NUM_REQ(2)) ifa ();
    remote_cmd_arbiter_if #(.NUM_REQ(3)) ifb ();

    remote_cmd_arbiter #(.NUM_REQ(2), .RESP_TIMEOUT(100)) u_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (ifa)
    );

    remote_cmd_arbiter #(.NUM_REQ(3), .RESP_TIMEOUT(16)) u_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_snd_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ifa.snd_cmd === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_snd_b(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ifb.snd_cmd === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({ifa.gnt, ifa.done, ifa.snd_cmd, ifa.timeout, ifa.resp_out, ifa.cmd} !== 30'd0) begin
            errors++;
            $display("FAIL reset_a: got gnt=%b done=%b snd=%b to=%b resp=%h cmd=%h want all 0",
                     ifa.gnt, ifa.done, ifa.snd_cmd, ifa.timeout, ifa.resp_out, ifa.cmd);
        end
        checks++;
        if ({ifb.gnt, ifb.done, ifb.snd_cmd, ifb.timeout, ifb.resp_out, ifb.cmd} !== 32'd0) begin
            errors++;
            $display("FAIL reset_b: got gnt=%b done=%b snd=%b to=%b resp=%h cmd=%h want all 0",
                     ifb.gnt, ifb.done, ifb.snd_cmd, ifb.timeout, ifb.resp_out, ifb.cmd);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bit bad;
        ifa.req_cmd = 32'h1234_A5C3;
        ifa.req     = 2'b01;
        tick();
        checks++;
        if (ifa.snd_cmd !== 1'b1 || ifa.gnt !== 2'b01 || ifa.cmd !== 16'hA5C3) begin
            errors++;
            $display("FAIL single_grant: got snd=%b gnt=%b cmd=%h want 1 01 a5c3", ifa.snd_cmd, ifa.gnt, ifa.cmd);
        end
        ifa.req = 2'b00;
        tick();
        checks++;
        if (ifa.snd_cmd !== 1'b0) begin
            errors++;
            $display("FAIL single_snd_width: got snd=%b want 0", ifa.snd_cmd);
        end
        bad = 1'b0;
        for (int i = 0; i < 19; i++) begin
            if (ifa.gnt !== 2'b01 || ifa.done !== 2'b00) bad = 1'b1;
            tick();
        end
        ifa.cmd_snt = 1'b1;
        tick();
        ifa.cmd_snt = 1'b0;
        for (int i = 0; i < 29; i++) begin
            if (ifa.gnt !== 2'b01 || ifa.done !== 2'b00 || ifa.snd_cmd !== 1'b0) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL single_hold: got gnt/done deviation while waiting want gnt=01 done=00");
        end
        ifa.resp     = 8'h5A;
        ifa.resp_rdy = 1'b1;
        tick();
        ifa.resp_rdy = 1'b0;
        checks++;
        if (ifa.done !== 2'b01 || ifa.gnt !== 2'b01 || ifa.resp_out !== 8'h5A || ifa.timeout !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got done=%b gnt=%b resp=%h to=%b want 01 01 5a 0",
                     ifa.done, ifa.gnt, ifa.resp_out, ifa.timeout);
        end
        tick();
        checks++;
        if (ifa.done !== 2'b00 || ifa.gnt !== 2'b00 || ifa.cmd !== 16'hA5C3) begin
            errors++;
            $display("FAIL single_end: got done=%b gnt=%b cmd=%h want 00 00 a5c3", ifa.done, ifa.gnt, ifa.cmd);
        end
    endtask

    task automatic test_round_robin();
        bit         ok;
        logic [1:0] exp_g;
        do_reset();
        ifa.req_cmd = 32'hBBBB_AAAA;
        ifa.req     = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            wait_snd_a(ok);
            checks++;
            if (!ok || ifa.gnt !== exp_g || ifa.cmd !== (exp_g == 2'b01 ? 16'hAAAA : 16'hBBBB)) begin
                errors++;
                $display("FAIL rr_grant%0d: got ok=%b gnt=%b cmd=%h want gnt=%b", t, ok, ifa.gnt, ifa.cmd, exp_g);
            end
            ifa.cmd_snt = 1'b1;
            tick();
            ifa.cmd_snt  = 1'b0;
            ifa.resp     = 8'(t + 1);
            ifa.resp_rdy = 1'b1;
            tick();
            ifa.resp_rdy = 1'b0;
            if (t == 3) ifa.req = 2'b00;
            checks++;
            if (ifa.done !== exp_g || ifa.resp_out !== 8'(t + 1)) begin
                errors++;
                $display("FAIL rr_done%0d: got done=%b resp=%h want %b %h", t, ifa.done, ifa.resp_out, exp_g, 8'(t + 1));
            end
            tick();
            checks++;
            if (ifa.gnt !== 2'b00 || ifa.snd_cmd !== 1'b0) begin
                errors++;
                $display("FAIL rr_idle_gap%0d: got gnt=%b snd=%b want 00 0", t, ifa.gnt, ifa.snd_cmd);
            end
        end
    endtask

    task automatic test_resp_at_expiry();
        bit ok;
        bit bad;
        do_reset();
        ifb.req_cmd = 48'h3333_2222_1111;
        ifb.req     = 3'b100;
        wait_snd_b(ok);
        checks++;
        if (!ok || ifb.gnt !== 3'b100 || ifb.cmd !== 16'h3333) begin
            errors++;
            $display("FAIL expiry_grant: got ok=%b gnt=%b cmd=%h want 100 3333", ok, ifb.gnt, ifb.cmd);
        end
        ifb.req     = 3'b000;
        ifb.cmd_snt = 1'b1;
        tick();
        ifb.cmd_snt = 1'b0;
        bad = 1'b0;
        for (int i = 1; i < 15; i++) begin
            if (ifb.done !== 3'b000) bad = 1'b1;
            tick();
        end
        ifb.resp     = 8'h3C;
        ifb.resp_rdy = 1'b1;
        if (ifb.done !== 3'b000) bad = 1'b1;
        tick();
        ifb.resp_rdy = 1'b0;
        checks++;
        if (bad || ifb.done !== 3'b100 || ifb.timeout !== 1'b0 || ifb.resp_out !== 8'h3C) begin
            errors++;
            $display("FAIL expiry_resp_wins: got early=%b done=%b to=%b resp=%h want 0 100 0 3c",
                     bad, ifb.done, ifb.timeout, ifb.resp_out);
        end
        tick();
        checks++;
        if (ifb.done !== 3'b000 || ifb.gnt !== 3'b000) begin
            errors++;
            $display("FAIL expiry_end: got done=%b gnt=%b want 000 000", ifb.done, ifb.gnt);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        bit bad;
        ifb.req = 3'b010;
        wait_snd_b(ok);
        checks++;
        if (!ok || ifb.gnt !== 3'b010 || ifb.cmd !== 16'h2222) begin
            errors++;
            $display("FAIL timeout_grant: got ok=%b gnt=%b cmd=%h want 010 2222", ok, ifb.gnt, ifb.cmd);
        end
        ifb.req     = 3'b000;
        ifb.cmd_snt = 1'b1;
        tick();
        ifb.cmd_snt = 1'b0;
        bad = 1'b0;
        for (int i = 1; i < 16; i++) begin
            if (ifb.done !== 3'b000 || ifb.gnt !== 3'b010) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad || ifb.done !== 3'b010 || ifb.timeout !== 1'b1 || ifb.resp_out !== 8'h00) begin
            errors++;
            $display("FAIL timeout_done: got early=%b done=%b to=%b resp=%h want 0 010 1 00",
                     bad, ifb.done, ifb.timeout, ifb.resp_out);
        end
        tick();
        ifb.req = 3'b001;
        wait_snd_b(ok);
        ifb.req = 3'b000;
        checks++;
        if (!ok || ifb.gnt !== 3'b001 || ifb.cmd !== 16'h1111) begin
            errors++;
            $display("FAIL timeout_next_grant: got ok=%b gnt=%b cmd=%h want 001 1111", ok, ifb.gnt, ifb.cmd);
        end
        ifb.cmd_snt = 1'b1;
        tick();
        ifb.cmd_snt  = 1'b0;
        ifb.resp     = 8'h77;
        ifb.resp_rdy = 1'b1;
        tick();
        ifb.resp_rdy = 1'b0;
        checks++;
        if (ifb.done !== 3'b001 || ifb.timeout !== 1'b0 || ifb.resp_out !== 8'h77) begin
            errors++;
            $display("FAIL timeout_next_done: got done=%b to=%b resp=%h want 001 0 77", ifb.done, ifb.timeout, ifb.resp_out);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit bad;
        ifa.req_cmd = 32'h0000_C0DE;
        ifa.req     = 2'b01;
        wait_snd_a(ok);
        ifa.req     = 2'b00;
        ifa.cmd_snt = 1'b1;
        tick();
        ifa.cmd_snt = 1'b0;
        tick();
        checks++;
        if (!ok || ifa.gnt !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_pre: got ok=%b gnt=%b want 1 01", ok, ifa.gnt);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ifa.gnt !== 2'b00 || ifa.done !== 2'b00 || ifa.snd_cmd !== 1'b0 || ifa.cmd !== 16'h0000) begin
            errors++;
            $display("FAIL rstmid_async: got gnt=%b done=%b snd=%b cmd=%h want 00 00 0 0000",
                     ifa.gnt, ifa.done, ifa.snd_cmd, ifa.cmd);
        end
        tick();
        tick();
        rst_n        = 1'b1;
        ifa.resp     = 8'hEE;
        ifa.resp_rdy = 1'b1;
        ifa.cmd_snt  = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ifa.done !== 2'b00 || ifa.gnt !== 2'b00 || ifa.snd_cmd !== 1'b0) bad = 1'b1;
        end
        ifa.resp_rdy = 1'b0;
        ifa.cmd_snt  = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rstmid_stray: got activity after stray link events want done=00 gnt=00");
        end
    endtask

    task automatic test_order3();
        bit         ok;
        logic [2:0] exp_g [4];
        logic [2:0] req_mid [4];
        logic [2:0] req_done [4];
        exp_g[0] = 3'b001; req_mid[0] = 3'b101; req_done[0] = 3'b101;
        exp_g[1] = 3'b100; req_mid[1] = 3'b001; req_done[1] = 3'b001;
        exp_g[2] = 3'b001; req_mid[2] = 3'b101; req_done[2] = 3'b001;
        exp_g[3] = 3'b001; req_mid[3] = 3'b000; req_done[3] = 3'b000;
        do_reset();
        ifb.req_cmd = 48'h3333_2222_1111;
        ifb.req     = 3'b001;
        for (int t = 0; t < 4; t++) begin
            wait_snd_b(ok);
            checks++;
            if (!ok || ifb.gnt !== exp_g[t]) begin
                errors++;
                $display("FAIL order3_grant%0d: got ok=%b gnt=%b want %b", t, ok, ifb.gnt, exp_g[t]);
            end
            ifb.req     = req_mid[t];
            ifb.cmd_snt = 1'b1;
            tick();
            ifb.cmd_snt  = 1'b0;
            ifb.resp     = 8'hA0 + 8'(t);
            ifb.resp_rdy = 1'b1;
            tick();
            ifb.resp_rdy = 1'b0;
            ifb.req      = req_done[t];
            checks++;
            if (ifb.done !== exp_g[t] || ifb.resp_out !== 8'hA0 + 8'(t)) begin
                errors++;
                $display("FAIL order3_done%0d: got done=%b resp=%h want %b %h", t, ifb.done, ifb.resp_out,
                         exp_g[t], 8'hA0 + 8'(t));
            end
        end
        tick();
        tick();
        checks++;
        if (ifb.gnt !== 3'b000 || ifb.snd_cmd !== 1'b0) begin
            errors++;
            $display("FAIL order3_quiet: got gnt=%b snd=%b want 000 0", ifb.gnt, ifb.snd_cmd);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        ifa.req      = 2'b00;
        ifa.req_cmd  = 32'h0;
        ifa.cmd_snt  = 1'b0;
        ifa.resp     = 8'h00;
        ifa.resp_rdy = 1'b0;
        ifb.req      = 3'b000;
        ifb.req_cmd  = 48'h0;
        ifb.cmd_snt  = 1'b0;
        ifb.resp     = 8'h00;
        ifb.resp_rdy = 1'b0;
        tick();
        test_reset();
        test_single();
        test_round_robin();
        test_resp_at_expiry();
        test_timeout();
        test_reset_mid();
        test_order3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
